// File: rtl/prn_sched_pkg.sv
// prn_sched_pkg: shared FSM state type, LFSR constants and the LFSR step function
package prn_sched_pkg;
  typedef enum logic {IDLE, ISSUE} state_e;
  localparam int LFSR_W = 6;
  localparam logic [LFSR_W-1:0] LFSR_RST = 6'h01;
  localparam int NREQ = 3;
  localparam int PRN_W = 3;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[4:0], s[5] ^ s[4]};
  endfunction
endpackage

// File: rtl/prn_lfsr6.sv
// prn_lfsr6: 6-bit maximal-length LFSR that steps on demand and accepts a parallel load
module prn_lfsr6 import prn_sched_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);
  logic [LFSR_W-1:0] state_d, state_q;
  always_comb state_d = load ? load_val : step ? lfsr_next(state_q) : state_q;
  always_ff @(posedge clk) state_q <= rst_n ? state_d : LFSR_RST;
  assign state = state_q;
endmodule

// File: rtl/prn_sched.sv
// prn_sched: tick-paced round-robin grant scheduler with LFSR word per grant (seed load under PRN_SEED_LOAD_EN)
module prn_sched import prn_sched_pkg::*; #(
  parameter int DIV_W = 23,
  parameter int NREQ  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PRN_SEED_LOAD_EN
  input  logic              seed_we,
  input  logic [LFSR_W-1:0] seed,
`endif
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [PRN_W-1:0]  prn,
  output logic [7:0]        gnt_cnt
);
  logic [DIV_W-1:0] div_d, div_q;
  state_e state_d, state_q;
  logic [1:0] last_d, last_q, s0, s1, s2, win;
  logic [NREQ-1:0] gnt_d, gnt_q;
  logic [PRN_W-1:0] prn_d, prn_q;
  logic [7:0] cnt_d, cnt_q;
  logic [LFSR_W-1:0] lfsr_state, lfsr_nxt, load_val;
  logic tick, load, fire;
`ifdef PRN_SEED_LOAD_EN
  assign load = seed_we;
  assign load_val = seed == '0 ? LFSR_RST : seed;
`else
  assign load = 1'b0;
  assign load_val = LFSR_RST;
`endif
  assign tick = &div_q;
  assign fire = state_q == IDLE && tick && |req && !load;
  assign lfsr_nxt = lfsr_next(lfsr_state);
  always_comb begin
    s0 = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
    s1 = s0 == 2'd2 ? 2'd0 : s0 + 2'd1;
    s2 = s1 == 2'd2 ? 2'd0 : s1 + 2'd1;
    win = req[s0] ? s0 : req[s1] ? s1 : s2;
    div_d = div_q + DIV_W'(1);
    state_d = fire ? ISSUE : IDLE;
    last_d = fire ? win : last_q;
    gnt_d = fire ? NREQ'(1) << win : '0;
    prn_d = fire ? {lfsr_nxt[1], lfsr_nxt[3], lfsr_nxt[5]} : '0;
    cnt_d = cnt_q + {7'd0, fire};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      state_q <= IDLE;
      last_q <= 2'd2;
      gnt_q <= '0;
      prn_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      state_q <= state_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      prn_q <= prn_d;
      cnt_q <= cnt_d;
    end
  end
  prn_lfsr6 u_lfsr (
    .clk(clk),
    .rst_n(rst_n),
    .step(fire),
    .load(load),
    .load_val(load_val),
    .state(lfsr_state)
  );
  assign gnt = gnt_q;
  assign prn = prn_q;
  assign gnt_cnt = cnt_q;
endmodule

// File: tb/tb_prn_sched.sv
// tb_prn_sched: directed scoreboard bench for prn_sched at DIV_W = 2
module tb_prn_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] gnt, prn;
  logic [7:0] gnt_cnt;
`ifdef PRN_SEED_LOAD_EN
  logic seed_we = 1'b0;
  logic [5:0] seed = '0;
`endif
  always #5 clk = ~clk;
  prn_sched #(.DIV_W(2), .NREQ(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef PRN_SEED_LOAD_EN
    .seed_we(seed_we),
    .seed(seed),
`endif
    .req(req),
    .gnt(gnt),
    .prn(prn),
    .gnt_cnt(gnt_cnt)
  );
  typedef struct {logic [2:0] g; logic [2:0] p;} exp_t;
  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int mdiv = 0;
  logic [5:0] ml = 6'h01;
  logic [1:0] mlast = 2'd2;
  logic [7:0] mc = '0;
  bit missue = 0;
  bit granted = 0;
  logic [2:0] seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic cyc();
    exp_t e;
    bit ld;
    bit found;
    logic [1:0] w;
    ld = 0;
    found = 0;
    w = '0;
`ifdef PRN_SEED_LOAD_EN
    ld = seed_we;
`endif
    if (!rst_n) begin
      mdiv = 0; ml = 6'h01; mlast = 2'd2; mc = '0; missue = 0;
    end else begin
`ifdef PRN_SEED_LOAD_EN
      if (ld) ml = (seed == 6'h00) ? 6'h01 : seed;
`endif
      if (!missue && mdiv == 3 && req != 3'b000 && !ld) begin
        for (int k = 1; k <= 3; k++) begin
          int i;
          i = (int'(mlast) + k) % 3;
          if (!found && req[i]) begin w = 2'(i); found = 1; end
        end
        ml = {ml[4:0], ml[5] ^ ml[4]};
        mlast = w;
        mc = mc + 8'd1;
        e.g = 3'b001 << w;
        e.p = {ml[1], ml[3], ml[5]};
        sbq.push_back(e);
        missue = 1;
      end else missue = 0;
      mdiv = (mdiv + 1) % 4;
    end
    @(posedge clk);
    #1;
    granted = 0;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("gnt", gnt, e.g);
      chk("prn", prn, e.p);
      granted = 1;
    end else begin
      chk("gnt_idle", gnt, 0);
      chk("prn_idle", prn, 0);
    end
    chk("lfsr", dut.lfsr_state, ml);
    chk("gnt_cnt", gnt_cnt, mc);
  endtask
  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!granted && n < 12);
    chk(tag, granted, 1);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask
  initial begin
    req = 3'b000;
    repeat (3) cyc();
    chk("rst_lfsr", dut.lfsr_state, 6'h01);
    chk("rst_last", dut.last_q, 2);
    rst_n = 1'b1;
    req = 3'b001;
    wait_grant("first_grant_timeout");
    chk("first_gnt", gnt, 3'b001);
    chk("first_prn", prn, 3'b100);
    chk("first_lfsr", dut.lfsr_state, 6'h02);
    chk("first_cnt", gnt_cnt, 1);
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_grant("rr_timeout");
      chk("rr_seq", gnt, seq[i]);
    end
    cyc();
    do_reset();
    req = 3'b001;
    for (int i = 0; i < 63; i++) begin
      wait_grant("period_timeout");
      chk("lfsr_nonzero", dut.lfsr_state != 6'h00, 1);
      if (i == 3) chk("lfsr_10", dut.lfsr_state, 6'h10);
      if (i == 4) chk("lfsr_21", dut.lfsr_state, 6'h21);
      if (i == 5) chk("lfsr_03", dut.lfsr_state, 6'h03);
    end
    chk("lfsr_period", dut.lfsr_state, 6'h01);
    chk("cnt_63", gnt_cnt, 63);
    do_reset();
    req = 3'b000;
    repeat (44) cyc();
    chk("idle_lfsr", dut.lfsr_state, 6'h01);
    chk("idle_cnt", gnt_cnt, 0);
    chk("idle_last", dut.last_q, 2);
    req = 3'b010;
    cyc();
    req = 3'b000;
    repeat (8) cyc();
    chk("drop_cnt", gnt_cnt, 0);
    do_reset();
    req = 3'b001;
    wait_grant("abort_timeout");
    rst_n = 1'b0;
    cyc();
    chk("abort_gnt", gnt, 0);
    chk("abort_lfsr", dut.lfsr_state, 6'h01);
    chk("abort_cnt", gnt_cnt, 0);
    chk("abort_last", dut.last_q, 2);
`ifdef PRN_SEED_LOAD_EN
    do_reset();
    req = 3'b001;
    repeat (3) cyc();
    seed_we = 1'b1;
    seed = 6'h00;
    cyc();
    seed_we = 1'b0;
    chk("seed_skip", granted, 0);
    chk("seed_lfsr", dut.lfsr_state, 6'h01);
    wait_grant("seed_timeout");
    chk("seed_gnt", gnt, 3'b001);
    chk("seed_lfsr2", dut.lfsr_state, 6'h02);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
